// File: rtl/reg_write_ctrl_pkg.sv
// Shared widths, defaults and types for the register-file write-side controller.
// Load-return FIFO entries and the write-port source select are defined here.
package reg_write_ctrl_pkg;

  localparam int REG_AW           = 5;
  localparam int DATA_W           = 32;
  localparam int NUM_REGS         = 32;
  localparam int LQ_DEPTH_DEF     = 2;
  localparam int STARVE_LIMIT_DEF = 4;

  typedef logic [REG_AW-1:0] reg_addr_t;
  typedef logic [DATA_W-1:0] reg_data_t;

  typedef struct packed {
    reg_addr_t rd;
    reg_data_t data;
  } load_entry_t;

  localparam int LOAD_ENTRY_W = $bits(load_entry_t);

  typedef enum logic [1:0] {
    SEL_NONE = 2'd0,
    SEL_ALU  = 2'd1,
    SEL_LOAD = 2'd2
  } wr_sel_e;

  // One-hot register mask; x0 maps to an empty mask since it is never pending.
  function automatic logic [NUM_REGS-1:0] reg_onehot(input reg_addr_t a);
    logic [NUM_REGS-1:0] v;
    v = '0;
    if (a != '0) v[a] = 1'b1;
    return v;
  endfunction

endpackage

// File: rtl/sync_fifo.sv
// Generic single-clock FIFO with show-ahead read data.
// Pointers carry one extra wrap bit so full and empty need no separate counter.
module sync_fifo #(
  parameter int DEPTH = 2,
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             i_push,
  input  logic             i_pop,
  input  logic [WIDTH-1:0] i_wdata,
  output logic [WIDTH-1:0] o_rdata,
  output logic             o_full,
  output logic             o_empty
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW:0]      r_wptr;
  logic [AW:0]      r_rptr;
  logic             w_push;
  logic             w_pop;

  assign o_empty = (r_wptr == r_rptr);
  assign o_full  = (r_wptr[AW] != r_rptr[AW]) && (r_wptr[AW-1:0] == r_rptr[AW-1:0]);
  assign w_push  = i_push & ~o_full;
  assign w_pop   = i_pop & ~o_empty;
  assign o_rdata = r_mem[r_rptr[AW-1:0]];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_wptr <= '0;
      r_rptr <= '0;
    end else begin
      if (w_push) r_wptr <= r_wptr + 1'b1;
      if (w_pop)  r_rptr <= r_rptr + 1'b1;
    end
  end

  // Storage needs no reset: entries are only visible between valid pointers.
  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wptr[AW-1:0]] <= i_wdata;
  end

endmodule

// File: rtl/reg_write_ctrl.sv
// Merges ALU results and buffered load returns onto the register file write port,
// and tracks loads in flight so decode can stall on RAW hazards.
module reg_write_ctrl
  import reg_write_ctrl_pkg::*;
#(
  parameter int LQ_DEPTH     = LQ_DEPTH_DEF,
  parameter int STARVE_LIMIT = STARVE_LIMIT_DEF
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              aluValid,
  input  logic [REG_AW-1:0] aluRd,
  input  logic [DATA_W-1:0] aluData,
  output logic              aluStall,
  input  logic              memValid,
  input  logic [REG_AW-1:0] memRd,
  input  logic [DATA_W-1:0] memData,
  output logic              memReady,
  input  logic              issueLoad,
  input  logic [REG_AW-1:0] issueRd,
  input  logic [REG_AW-1:0] rdAddr1,
  input  logic [REG_AW-1:0] rdAddr2,
  output logic              hazard1,
  output logic              hazard2,
  output logic              wen,
  output logic [REG_AW-1:0] regWAddr,
  output logic [DATA_W-1:0] regWData
);

  localparam int                SC_W       = $clog2(STARVE_LIMIT + 1);
  localparam logic [SC_W-1:0]   STARVE_MAX = SC_W'(STARVE_LIMIT);

  load_entry_t          w_push_entry;
  load_entry_t          w_head;
  logic                 w_fifo_full;
  logic                 w_fifo_empty;
  logic                 w_push;
  logic                 w_pop;
  logic                 w_force_load;
  wr_sel_e              w_sel;
  logic [NUM_REGS-1:0]  w_set_mask;
  logic [NUM_REGS-1:0]  w_clr_mask;

  logic [SC_W-1:0]      r_starve_cnt;
  logic [NUM_REGS-1:0]  r_pending;

  always_comb begin
    w_push_entry      = '0;
    w_push_entry.rd   = memRd;
    w_push_entry.data = memData;
  end

  assign memReady = ~w_fifo_full;
  assign w_push   = memValid & ~w_fifo_full;

  sync_fifo #(
    .DEPTH (LQ_DEPTH),
    .WIDTH (LOAD_ENTRY_W)
  ) u_load_fifo (
    .clk     (clk),
    .reset   (reset),
    .i_push  (w_push),
    .i_pop   (w_pop),
    .i_wdata (w_push_entry),
    .o_rdata (w_head),
    .o_full  (w_fifo_full),
    .o_empty (w_fifo_empty)
  );

  // A load that has lost STARVE_LIMIT times in a row pre-empts the ALU.
  assign w_force_load = ~w_fifo_empty & (r_starve_cnt == STARVE_MAX);

  always_comb begin
    w_sel = SEL_NONE;
    if (w_force_load)       w_sel = SEL_LOAD;
    else if (aluValid)      w_sel = SEL_ALU;
    else if (~w_fifo_empty) w_sel = SEL_LOAD;
  end

  assign w_pop    = (w_sel == SEL_LOAD);
  assign aluStall = aluValid & w_force_load;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_starve_cnt <= '0;
    end else if (w_pop) begin
      r_starve_cnt <= '0;
    end else if ((w_sel == SEL_ALU) && ~w_fifo_empty && (r_starve_cnt != STARVE_MAX)) begin
      r_starve_cnt <= r_starve_cnt + 1'b1;
    end
  end

  // Address/data hold when idle; an x0 destination consumes its slot with wen low.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wen      <= 1'b0;
      regWAddr <= '0;
      regWData <= '0;
    end else begin
      case (w_sel)
        SEL_ALU: begin
          wen      <= (aluRd != '0);
          regWAddr <= aluRd;
          regWData <= aluData;
        end
        SEL_LOAD: begin
          wen      <= (w_head.rd != '0);
          regWAddr <= w_head.rd;
          regWData <= w_head.data;
        end
        default: wen <= 1'b0;
      endcase
    end
  end

  assign w_set_mask = issueLoad ? reg_onehot(issueRd) : '0;
  assign w_clr_mask = w_pop ? reg_onehot(w_head.rd) : '0;

  // Set is applied after clear so a re-issued load to the same register stays pending.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_pending <= '0;
    end else begin
      r_pending <= ((r_pending & ~w_clr_mask) | w_set_mask) & ~NUM_REGS'(1);
    end
  end

  assign hazard1 = r_pending[rdAddr1];
  assign hazard2 = r_pending[rdAddr2];

endmodule

// File: tb/tb_reg_write_ctrl.sv
// Directed bench for reg_write_ctrl: ALU path, load path, backpressure,
// starvation override, scoreboard set/clear race and mid-operation reset.
module tb_reg_write_ctrl;

  logic        clk;
  logic        reset;
  logic        aluValid;
  logic [4:0]  aluRd;
  logic [31:0] aluData;
  logic        aluStall;
  logic        memValid;
  logic [4:0]  memRd;
  logic [31:0] memData;
  logic        memReady;
  logic        issueLoad;
  logic [4:0]  issueRd;
  logic [4:0]  rdAddr1;
  logic [4:0]  rdAddr2;
  logic        hazard1;
  logic        hazard2;
  logic        wen;
  logic [4:0]  regWAddr;
  logic [31:0] regWData;

  int n_tests;
  int n_fail;

  reg_write_ctrl dut (
    .clk       (clk),
    .reset     (reset),
    .aluValid  (aluValid),
    .aluRd     (aluRd),
    .aluData   (aluData),
    .aluStall  (aluStall),
    .memValid  (memValid),
    .memRd     (memRd),
    .memData   (memData),
    .memReady  (memReady),
    .issueLoad (issueLoad),
    .issueRd   (issueRd),
    .rdAddr1   (rdAddr1),
    .rdAddr2   (rdAddr2),
    .hazard1   (hazard1),
    .hazard2   (hazard2),
    .wen       (wen),
    .regWAddr  (regWAddr),
    .regWData  (regWData)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    @(negedge clk);
  endtask

  initial begin
    n_tests = 0;
    n_fail  = 0;
    reset = 1'b1;
    aluValid = 0; aluRd = 0; aluData = 0;
    memValid = 0; memRd = 0; memData = 0;
    issueLoad = 0; issueRd = 0; rdAddr1 = 0; rdAddr2 = 0;

    // Reset state
    @(negedge clk);
    tick();
    check("rst_wen", wen, 0);
    check("rst_waddr", regWAddr, 0);
    check("rst_wdata", regWData, 0);
    check("rst_memready", memReady, 1);
    check("rst_alustall", aluStall, 0);
    check("rst_hazard1", hazard1, 0);
    reset = 1'b0;

    // ALU path: one-cycle latency, x0 suppresses wen, idle holds addr/data
    aluValid = 1; aluRd = 5; aluData = 32'h1234;
    #1 check("alu_stall", aluStall, 0);
    tick();
    check("alu_wen", wen, 1);
    check("alu_waddr", regWAddr, 5);
    check("alu_wdata", regWData, 32'h1234);
    aluRd = 0; aluData = 32'h5555;
    tick();
    check("alu_x0_wen", wen, 0);
    aluValid = 0; aluData = 0;
    tick();
    check("idle_wen", wen, 0);
    check("idle_hold_waddr", regWAddr, 0);
    check("idle_hold_wdata", regWData, 32'h5555);

    // Load path: scoreboard set, two-cycle write latency, hazard clears with write
    issueLoad = 1; issueRd = 7; rdAddr1 = 7; rdAddr2 = 3;
    #1 check("ld_hazard_before", hazard1, 0);
    tick();
    issueLoad = 0;
    check("ld_hazard1_set", hazard1, 1);
    check("ld_hazard2_other", hazard2, 0);
    memValid = 1; memRd = 7; memData = 32'hDEADBEEF;
    #1 check("ld_memready", memReady, 1);
    tick();
    memValid = 0;
    check("ld_n1_wen", wen, 0);
    check("ld_n1_hazard", hazard1, 1);
    tick();
    check("ld_n2_wen", wen, 1);
    check("ld_n2_waddr", regWAddr, 7);
    check("ld_n2_wdata", regWData, 32'hDEADBEEF);
    check("ld_hazard_clr", hazard1, 0);

    // Backpressure: two pushes fill the FIFO while the ALU is busy
    aluValid = 1; aluRd = 1; aluData = 32'hA0;
    memValid = 1; memRd = 10; memData = 32'hA1;
    #1 check("bp_ready_a", memReady, 1);
    tick();
    aluData = 32'hB0; memRd = 11; memData = 32'hB1;
    #1 check("bp_ready_b", memReady, 1);
    tick();
    check("bp_alu_b", regWData, 32'hB0);
    aluData = 32'hC0; memRd = 12; memData = 32'hC1;
    #1 check("bp_full_c", memReady, 0);
    tick();
    check("bp_alu_c", regWData, 32'hC0);
    aluValid = 0;
    #1 check("bp_full_d", memReady, 0);
    tick();
    check("bp_pop1_waddr", regWAddr, 10);
    check("bp_pop1_wdata", regWData, 32'hA1);
    check("bp_ready_e", memReady, 1);
    tick();
    memValid = 0;
    check("bp_pop2_waddr", regWAddr, 11);
    check("bp_pop2_wdata", regWData, 32'hB1);
    tick();
    check("bp_pop3_wen", wen, 1);
    check("bp_pop3_waddr", regWAddr, 12);
    check("bp_pop3_wdata", regWData, 32'hC1);
    tick();
    check("bp_drained_wen", wen, 0);

    // Starvation: one buffered load loses four times, then forces through
    aluValid = 1; aluRd = 2; aluData = 32'h100;
    memValid = 1; memRd = 13; memData = 32'hCAFE;
    tick();
    memValid = 0;
    check("st_alu0", regWData, 32'h100);
    for (int k = 1; k <= 4; k++) begin
      aluData = 32'h100 + 32'(k);
      #1 check("st_nostall", aluStall, 0);
      tick();
      check("st_alu_wdata", regWData, 32'h100 + 32'(k));
    end
    aluData = 32'h105;
    #1 check("st_force_stall", aluStall, 1);
    tick();
    check("st_force_waddr", regWAddr, 13);
    check("st_force_wdata", regWData, 32'hCAFE);
    #1 check("st_after_stall", aluStall, 0);
    tick();
    check("st_held_waddr", regWAddr, 2);
    check("st_held_wdata", regWData, 32'h105);
    aluValid = 0;

    // Scoreboard race: re-issue to rd 9 at the edge its older load is written
    issueLoad = 1; issueRd = 9; rdAddr2 = 9;
    tick();
    issueLoad = 0;
    check("race_set", hazard2, 1);
    memValid = 1; memRd = 9; memData = 32'h99;
    tick();
    memValid = 0;
    issueLoad = 1; issueRd = 9;
    tick();
    issueLoad = 0;
    check("race_pop_waddr", regWAddr, 9);
    check("race_pop_wdata", regWData, 32'h99);
    check("race_set_wins", hazard2, 1);
    memValid = 1; memRd = 9; memData = 32'h9A;
    tick();
    memValid = 0;
    tick();
    check("race_final_wdata", regWData, 32'h9A);
    check("race_final_clr", hazard2, 0);

    // Reset mid-operation with two buffered loads and pending bits
    aluValid = 1; aluRd = 3; aluData = 32'h300;
    issueLoad = 1; issueRd = 20;
    memValid = 1; memRd = 20; memData = 32'h2000;
    tick();
    issueRd = 21; memRd = 21; memData = 32'h2100;
    tick();
    issueLoad = 0; memValid = 0; rdAddr1 = 20; rdAddr2 = 21;
    #1 check("mr_full", memReady, 0);
    check("mr_hz1_pre", hazard1, 1);
    check("mr_hz2_pre", hazard2, 1);
    check("mr_waddr_pre", regWAddr, 3);
    reset = 1'b1;
    #1 check("mr_wen", wen, 0);
    check("mr_waddr", regWAddr, 0);
    check("mr_wdata", regWData, 0);
    check("mr_memready", memReady, 1);
    check("mr_alustall", aluStall, 0);
    check("mr_hz1", hazard1, 0);
    check("mr_hz2", hazard2, 0);
    tick();
    reset = 1'b0;
    aluValid = 0;
    for (int k = 0; k < 4; k++) begin
      tick();
      check("mr_no_write", wen, 0);
    end
    check("mr_ready_after", memReady, 1);
    check("mr_hz1_after", hazard1, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/reg_write_ctrl.md
Name: reg_write_ctrl

Overview:
- Write-side controller for the 32x32 general register file in the mini CPU.
- Merges two result sources into the register file's single write port (wen, regWAddr, regWData):
  - single-cycle ALU results;
  - out-of-order-latency load returns, buffered in a small FIFO.
- Keeps a per-register pending-load scoreboard so decode can detect RAW hazards on outstanding loads.
- Sits between the execute/memory stages and the register file; decode queries it alongside the register file's read ports.

Parameters:
- LQ_DEPTH, 2, load-return FIFO depth (power of two, ≥2).
- STARVE_LIMIT, 4, consecutive cycles in which a non-empty FIFO may lose to the ALU before the load is forced through.

Ports:
- clk  input  1  clock.
- reset  input  1  asynchronous reset, active-high.
- aluValid  input  1  ALU result present this cycle.
- aluRd  input  5  ALU destination register.
- aluData  input  32  ALU result.
- aluStall  output  1  ALU result not consumed this cycle; upstream holds it.
- memValid  input  1  load data returning.
- memRd  input  5  load destination register.
- memData  input  32  load data.
- memReady  output  1  FIFO can accept a load return.
- issueLoad  input  1  a load is issued this cycle.
- issueRd  input  5  destination of the issued load.
- rdAddr1  input  5  decode source register 1.
- rdAddr2  input  5  decode source register 2.
- hazard1  output  1  rdAddr1 has a pending load.
- hazard2  output  1  rdAddr2 has a pending load.
- wen  output  1  register file write enable (registered).
- regWAddr  output  5  register file write address (registered).
- regWData  output  32  register file write data (registered).

Behaviour:
- Reset (async, any time):
  - Outputs: wen=0, regWAddr=0, regWData=0.
  - FIFO emptied; starve counter=0; scoreboard all 0.
  - aluStall=0 and memReady=1 while reset is held.
  - A mid-operation reset discards buffered loads; no partial write is issued.
- FIFO:
  - memReady = !full (combinational).
  - Push on memValid & memReady.
  - When full, no push even if a pop occurs in the same cycle.
  - memValid while !memReady is ignored; the source must hold its data.
- Arbitration, evaluated each cycle (forceLoad = FIFO non-empty & starveCnt == STARVE_LIMIT):
  - forceLoad: pop FIFO head to the write port; aluStall = aluValid.
  - Else if aluValid: ALU wins; aluStall=0; starveCnt increments if the FIFO is non-empty (saturating at STARVE_LIMIT).
  - Else if FIFO non-empty: pop head to the write port.
  - Any FIFO pop clears starveCnt to 0.
- Write port registers, updated at the clock edge:
  - wen = selected source valid & (selected rd != 0).
  - regWAddr and regWData take the selected source values.
  - When nothing is selected, wen=0 and regWAddr/regWData hold their previous values.
  - An x0 destination still consumes its slot or FIFO entry but produces wen=0.
- Latency:
  - ALU result in cycle N → wen in cycle N+1.
  - Load accepted in cycle N → earliest wen in cycle N+2.
- Scoreboard (32 bits, bit 0 constant 0):
  - Set on issueLoad & issueRd != 0.
  - Cleared at the same edge a popped load entry is registered to the write port.
  - Same-cycle set and clear of the same register: set wins.
  - hazard1 = pending[rdAddr1] and hazard2 = pending[rdAddr2] (combinational).
  - Writes of an ALU result never touch the scoreboard.
- Ordering: load returns are written in FIFO arrival order.

Decomposition:
- Shared package: register-address width (5), data width (32), register count (32), LQ_DEPTH default, STARVE_LIMIT default.
- One sub-module: sync_fifo, parameterised by depth/width, with push/pop/full/empty. The same codebase reuses it for other buffers.

Test Plan:
- ALU only: aluValid=1, aluRd=5, aluData=0x1234 in cycle N → wen=1, regWAddr=5, regWData=0x1234 in N+1; aluRd=0 → wen stays 0.
- Load path: issueLoad with issueRd=7 → hazard1=1 when rdAddr1=7. Then memValid with memRd=7, memData=0xDEADBEEF in cycle N with aluValid=0 → write in N+2, and hazard1 drops at the same edge.
- Backpressure: three back-to-back load returns while the ALU is busy → memReady=0 after two pushes; the third is accepted only after the first pop.
- Starvation: FIFO holds one entry and aluValid=1 every cycle → ALU wins 4 cycles. On the 5th cycle aluStall=1 and the load is written; the held ALU result is written on the next cycle.
- Scoreboard race: issueLoad to rd 9 in the same cycle an older load to rd 9 is popped → pending[9] remains 1.
- Reset mid-operation: assert reset with 2 entries buffered and pending bits set → all outputs 0, memReady=1, hazard1 and hazard2 = 0, and no write occurs after release.
